// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch sequencer.
//   fetch_state_e    : fetch FSM states
//   RESET_PC_DEFAULT : default PC loaded on reset
//   PC_STEP_DEFAULT  : default sequential PC increment in bytes
package fetch_pkg;

  localparam int unsigned XLEN_DEFAULT     = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned PC_STEP_DEFAULT  = 4;

  typedef enum logic [2:0] {
    BOOT  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    FAULT = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/fetch_redirect_buf.sv
// Pending-redirect buffer: remembers the newest redirect target seen while a
// fetch is outstanding so the in-flight response can be discarded.
//   CLK, Reset_n : clock, async active-low reset
//   set          : capture set_target as the pending redirect
//   set_target   : redirect target
//   clear        : drop the pending redirect (wins over set)
//   pending_c    : redirect pending, including one being set this cycle
//   target_c     : newest pending target, including one being set this cycle
module fetch_redirect_buf
  import fetch_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic            CLK,
  input  logic            Reset_n,
  input  logic            set,
  input  logic [XLEN-1:0] set_target,
  input  logic            clear,
  output logic            pending_c,
  output logic [XLEN-1:0] target_c
);

  logic            pending_q;
  logic [XLEN-1:0] target_q;

  // Pending flag/target register; clear takes priority over a new capture.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      pending_q <= 1'b0;
      target_q  <= '0;
    end else if (clear) begin
      pending_q <= 1'b0;
    end else if (set) begin
      pending_q <= 1'b1;
      target_q  <= set_target;
    end
  end

  // Bypass so a redirect arriving with the response is not lost (newest wins).
  assign pending_c = set | pending_q;
  assign target_c  = set ? set_target : target_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC and sequences one outstanding
// request against a handshaked instruction memory, with decode back-pressure
// and ALU branch/jump redirect.
//   CLK, Reset_n            : clock, async active-low reset
//   PCSrc, AluOutput        : redirect request and target
//   imem_req_valid/addr     : fetch request (held until imem_req_ready)
//   imem_rsp_valid/data     : fetch response, one-cycle pulse
//   inst_valid/data/pc      : instruction to decode (held until inst_ready)
//   curPC                   : PC of the current or next fetch
//   fetch_misalign          : only with FETCH_ALIGN_CHECK_EN; set when a
//                             misaligned redirect parks the FSM in FAULT
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT),
  parameter int unsigned     PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic            CLK,
  input  logic            Reset_n,
  input  logic            PCSrc,
  input  logic [XLEN-1:0] AluOutput,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc,
  input  logic            inst_ready,
`ifdef FETCH_ALIGN_CHECK_EN
  output logic            fetch_misalign,
`endif
  output logic [XLEN-1:0] curPC
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] cur_pc_d;
  logic            req_valid_d;
  logic            inst_valid_d;
  logic [XLEN-1:0] inst_data_d;
  logic [XLEN-1:0] inst_pc_d;
  logic            redir_set;
  logic            redir_clear;
  logic            redir_pending_c;
  logic [XLEN-1:0] redir_target_c;
  logic            redirect_bad;

  fetch_redirect_buf #(.XLEN(XLEN)) u_redirect_buf (
    .CLK        (CLK),
    .Reset_n    (Reset_n),
    .set        (redir_set),
    .set_target (AluOutput),
    .clear      (redir_clear),
    .pending_c  (redir_pending_c),
    .target_c   (redir_target_c)
  );

  // A redirect to a non-word-aligned target is fatal only when checking is built in.
`ifdef FETCH_ALIGN_CHECK_EN
  assign redirect_bad = PCSrc && (AluOutput[1:0] != 2'b00);
`else
  assign redirect_bad = 1'b0;
`endif

  // Request address is the PC register itself, so it is stable throughout REQ.
  assign imem_req_addr = curPC;

  // State, PC and output registers.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q        <= BOOT;
      curPC          <= RESET_PC;
      imem_req_valid <= 1'b0;
      inst_valid     <= 1'b0;
      inst_data      <= '0;
      inst_pc        <= '0;
    end else begin
      state_q        <= state_d;
      curPC          <= cur_pc_d;
      imem_req_valid <= req_valid_d;
      inst_valid     <= inst_valid_d;
      inst_data      <= inst_data_d;
      inst_pc        <= inst_pc_d;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  // Sticky misalign indication, mirrors residence in FAULT.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      fetch_misalign <= 1'b0;
    end else begin
      fetch_misalign <= (state_d == FAULT);
    end
  end
`endif

  // Next-state, next-PC and next-output logic.
  always_comb begin
    state_d      = state_q;
    cur_pc_d     = curPC;
    req_valid_d  = 1'b0;
    inst_valid_d = inst_valid;
    inst_data_d  = inst_data;
    inst_pc_d    = inst_pc;
    redir_set    = 1'b0;
    redir_clear  = 1'b0;

    case (state_q)
      BOOT: state_d = REQ;
      REQ: begin
        // A redirect here is deferred: the request still completes.
        redir_set = PCSrc;
        if (imem_req_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        redir_set = PCSrc;
        if (imem_rsp_valid) begin
          if (redir_pending_c) begin
            // Response belongs to a stale path; refetch from the redirect target.
            cur_pc_d    = redir_target_c;
            redir_clear = 1'b1;
            state_d     = REQ;
          end else begin
            inst_data_d  = imem_rsp_data;
            inst_pc_d    = curPC;
            inst_valid_d = 1'b1;
            state_d      = HOLD;
          end
        end
      end
      HOLD: begin
        // Redirect beats the sequential step whether or not decode accepts.
        if (PCSrc) begin
          cur_pc_d     = AluOutput;
          inst_valid_d = 1'b0;
          state_d      = REQ;
        end else if (inst_ready) begin
          cur_pc_d     = curPC + XLEN'(PC_STEP);
          inst_valid_d = 1'b0;
          state_d      = REQ;
        end
      end
      FAULT: inst_valid_d = 1'b0;
      default: state_d = BOOT;
    endcase

    if (redirect_bad && (state_q inside {REQ, WAIT, HOLD})) begin
      state_d      = FAULT;
      cur_pc_d     = curPC;
      inst_valid_d = 1'b0;
      redir_set    = 1'b0;
      redir_clear  = 1'b1;
    end

    req_valid_d = (state_d == REQ);
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a one-outstanding memory responder
// and a scoreboard of expected request addresses and decoded instructions.
module tb_fetch_sequencer;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } inst_t;

  logic        CLK;
  logic        Reset_n;
  logic        PCSrc;
  logic [31:0] AluOutput;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic [31:0] curPC;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        fetch_misalign;
`endif

  logic [31:0] exp_req[$];
  inst_t       exp_inst[$];
  int          hs_times[$];
  int          errors  = 0;
  int          checks  = 0;
  int          cyc_cnt = 0;
  int          rsp_lat = 1;
  int          lat;
  logic [31:0] rsp_addr;
  inst_t       mon_e;

  fetch_sequencer dut (
    .CLK            (CLK),
    .Reset_n        (Reset_n),
    .PCSrc          (PCSrc),
    .AluOutput      (AluOutput),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
`ifdef FETCH_ALIGN_CHECK_EN
    .fetch_misalign (fetch_misalign),
`endif
    .curPC          (curPC)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial forever begin
    @(posedge CLK);
    cyc_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hA5C3, ~a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_inst_valid(input string tag);
    for (int n = 0; n < 40 && !inst_valid; n++) step();
    chk(tag, 32'(inst_valid), 32'd1);
  endtask

  // Memory model: one response rsp_lat cycles after each accepted request.
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge CLK);
      if (Reset_n && imem_req_valid && imem_req_ready) begin
        rsp_addr = imem_req_addr;
        lat      = rsp_lat;
        repeat (lat) @(posedge CLK);
        #1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(rsp_addr);
        @(posedge CLK);
        #1;
        imem_rsp_valid = 1'b0;
      end
    end
  end

  // Scoreboard: every accepted request and consumed instruction must be expected.
  initial forever begin
    @(negedge CLK);
    if (Reset_n) begin
      if (imem_req_valid && imem_req_ready) begin
        checks++;
        assert (exp_req.size() > 0) else begin
          errors++;
          $error("FAIL req_unexpected observed=%h expected=none", imem_req_addr);
        end
        if (exp_req.size() > 0) chk("req_addr", imem_req_addr, exp_req.pop_front());
      end
      if (inst_valid && inst_ready) begin
        hs_times.push_back(cyc_cnt);
        checks++;
        assert (exp_inst.size() > 0) else begin
          errors++;
          $error("FAIL inst_unexpected observed=%h expected=none", inst_pc);
        end
        if (exp_inst.size() > 0) begin
          mon_e = exp_inst.pop_front();
          chk("inst_pc", inst_pc, mon_e.pc);
          chk("inst_data", inst_data, mon_e.data);
        end
      end
    end
  end

  initial begin
    Reset_n        = 1'b0;
    PCSrc          = 1'b0;
    AluOutput      = '0;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    rsp_lat        = 1;
    step();
    step();

    // Reset values
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst_data", inst_data, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_curpc", curPC, 32'd0);

    // Streaming fetch with ready memory and decode
    exp_req.push_back(32'h0);
    exp_req.push_back(32'h4);
    exp_req.push_back(32'h8);
    exp_req.push_back(32'hC);
    exp_inst.push_back('{pc: 32'h0, data: mem_word(32'h0)});
    exp_inst.push_back('{pc: 32'h4, data: mem_word(32'h4)});
    exp_inst.push_back('{pc: 32'h8, data: mem_word(32'h8)});
    Reset_n = 1'b1;
    for (int n = 0; n < 60 && hs_times.size() < 3; n++) step();
    inst_ready = 1'b0;
    chk("t1_inst_count", 32'(hs_times.size()), 32'd3);
    if (hs_times.size() >= 3) begin
      chk("t1_period_a", 32'(hs_times[1] - hs_times[0]), 32'd3);
      chk("t1_period_b", 32'(hs_times[2] - hs_times[1]), 32'd3);
    end

    // Decode back-pressure in HOLD
    wait_inst_valid("t2_valid");
    chk("t2_inst_pc", inst_pc, 32'hC);
    chk("t2_inst_data", inst_data, mem_word(32'hC));
    chk("t2_curpc", curPC, 32'hC);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t2_hold_valid", 32'(inst_valid), 32'd1);
      chk("t2_hold_data", inst_data, mem_word(32'hC));
      chk("t2_hold_curpc", curPC, 32'hC);
    end
    imem_req_ready = 1'b0;
    exp_inst.push_back('{pc: 32'hC, data: mem_word(32'hC)});
    exp_req.push_back(32'h10);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    chk("t2_curpc_adv", curPC, 32'h10);
    chk("t2_valid_drop", 32'(inst_valid), 32'd0);

    // Memory back-pressure in REQ
    for (int i = 0; i < 4; i++) begin
      chk("t3_req_valid", 32'(imem_req_valid), 32'd1);
      chk("t3_req_addr", imem_req_addr, 32'h10);
      step();
    end

    // Redirect while waiting for the response
    rsp_lat = 3;
    exp_req.push_back(32'h100);
    imem_req_ready = 1'b1;
    step();
    PCSrc     = 1'b1;
    AluOutput = 32'h100;
    step();
    PCSrc     = 1'b0;
    AluOutput = 32'h0000_0ABC;
    chk("t4_curpc_wait", curPC, 32'h10);
    wait_inst_valid("t4_valid");
    chk("t4_inst_pc", inst_pc, 32'h100);
    chk("t4_inst_data", inst_data, mem_word(32'h100));

    // Redirect coincident with decode accept in HOLD
    exp_inst.push_back('{pc: 32'h100, data: mem_word(32'h100)});
    exp_req.push_back(32'h200);
    PCSrc      = 1'b1;
    AluOutput  = 32'h200;
    inst_ready = 1'b1;
    step();
    PCSrc      = 1'b0;
    inst_ready = 1'b0;
    chk("t5_curpc", curPC, 32'h200);
    chk("t5_valid_drop", 32'(inst_valid), 32'd0);
    chk("t5_req_valid", 32'(imem_req_valid), 32'd1);
    chk("t5_req_addr", imem_req_addr, 32'h200);

    // Reset while a response is outstanding
    step();
    Reset_n = 1'b0;
    #1;
    chk("t6_req_valid", 32'(imem_req_valid), 32'd0);
    chk("t6_inst_valid", 32'(inst_valid), 32'd0);
    chk("t6_inst_data", inst_data, 32'd0);
    chk("t6_inst_pc", inst_pc, 32'd0);
    chk("t6_curpc", curPC, 32'd0);
    step();
    step();
    rsp_lat = 1;
    exp_req.push_back(32'h0);
    exp_inst.push_back('{pc: 32'h0, data: mem_word(32'h0)});
    inst_ready = 1'b1;
    Reset_n    = 1'b1;
    for (int n = 0; n < 40 && exp_inst.size() > 0; n++) step();
    imem_req_ready = 1'b0;
    step();
    step();
    step();
    chk("queues_drained", 32'(exp_req.size() + exp_inst.size()), 32'd0);
    chk("end_curpc", curPC, 32'h4);
    chk("end_req_valid", 32'(imem_req_valid), 32'd1);
    chk("end_req_addr", imem_req_addr, 32'h4);

`ifdef FETCH_ALIGN_CHECK_EN
    // Misaligned redirect parks the fetcher until reset
    PCSrc     = 1'b1;
    AluOutput = 32'h102;
    step();
    PCSrc = 1'b0;
    chk("t7_misalign", 32'(fetch_misalign), 32'd1);
    chk("t7_req_valid", 32'(imem_req_valid), 32'd0);
    chk("t7_inst_valid", 32'(inst_valid), 32'd0);
    imem_req_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t7_no_req", 32'(imem_req_valid), 32'd0);
      chk("t7_misalign_sticky", 32'(fetch_misalign), 32'd1);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Multi-cycle instruction-fetch controller that owns the program counter and sequences it against a handshaked instruction memory.
- Replaces the free-running curPC/nextPC update with a fetch FSM. It supports one outstanding request, decode back-pressure and branch/jump redirect from the ALU.
- Sits between instruction memory and decode. The ALU redirect path (PCSrc/AluOutput) feeds it directly.

Parameters:
- XLEN, 32, PC/address/instruction width
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- PC_STEP, 4, sequential PC increment in bytes

Ports:
- CLK  input  1  clock, all state on posedge
- Reset_n  input  1  asynchronous active-low reset
- PCSrc  input  1  redirect request, 1 = take AluOutput
- AluOutput  input  XLEN  redirect target
- imem_req_valid  output  1  fetch request valid
- imem_req_addr  output  XLEN  fetch address
- imem_req_ready  input  1  memory accepts request
- imem_rsp_valid  input  1  fetch data valid, one-cycle pulse
- imem_rsp_data  input  XLEN  fetched instruction
- inst_valid  output  1  instruction to decode valid
- inst_data  output  XLEN  instruction to decode
- inst_pc  output  XLEN  PC of inst_data
- inst_ready  input  1  decode accepts instruction
- curPC  output  XLEN  PC of the current or next fetch

Behaviour:
- Reset (async, Reset_n low):
  - state=BOOT, curPC=RESET_PC.
  - imem_req_valid=0, inst_valid=0, inst_data=0, inst_pc=0.
  - Redirect-pending flag cleared.
  - Reset mid-request drops any in-flight response; a response arriving in BOOT is ignored.
- States:
  - BOOT: one cycle, then REQ.
  - REQ: imem_req_valid=1, imem_req_addr=curPC, both held stable until imem_req_ready. On handshake go to WAIT.
  - WAIT: await imem_rsp_valid.
    - Pending redirect: discard data, curPC<=pending target, clear flag, go to REQ.
    - Otherwise: inst_data<=rsp, inst_pc<=curPC, inst_valid<=1, go to HOLD.
  - HOLD: inst_valid held until inst_ready.
    - On handshake: curPC<=curPC+PC_STEP (mod 2^XLEN), inst_valid<=0, go to REQ.
- Redirect (PCSrc=1, sampled every cycle outside BOOT):
  - In REQ or WAIT: latch AluOutput into the pending target and set the flag. The outstanding request still completes, and its data is discarded.
  - In REQ, a redirect in the same cycle as the handshake is handled identically.
  - In HOLD: drop the held instruction (inst_valid<=0 next cycle), curPC<=AluOutput, go to REQ.
  - Redirect coincident with inst_ready in HOLD: the instruction is consumed and curPC<=AluOutput (redirect beats +PC_STEP).
  - Multiple redirects before resolution: the newest target wins.
- Latency: request at cycle t with ready=1 and a response at t+1 gives inst_valid at t+2. The best case is one instruction per 3 cycles.
- curPC wraps at 2^XLEN without a flag.

Optional Feature:
- FETCH_ALIGN_CHECK_EN defined:
  - Adds an output port fetch_misalign (1 bit, reset 0).
  - A redirect target with AluOutput[1:0]!=0 is not fetched. The FSM enters state FAULT: fetch_misalign=1, imem_req_valid=0, inst_valid=0.
  - FAULT exits only by reset.
- Undefined: the port is absent, and targets are used verbatim (low bits passed to imem).

Decomposition:
- Package fetch_pkg:
  - state enum (BOOT, REQ, WAIT, HOLD, FAULT)
  - RESET_PC default constant
  - PC_STEP constant
- Sub-module fetch_redirect_buf: holds the pending flag/target, with set, clear and newest-wins logic.
- The FSM and PC register stay in the top module.

Test Plan:
- Reset release, memory always ready, rsp 1 cycle later, inst_ready=1:
  - Request addresses are 0x0, 0x4, 0x8.
  - inst_pc matches each address, and a new inst_valid arrives every 3 cycles.
- imem_req_ready low for 4 cycles in REQ -> imem_req_addr stays constant and valid stays high. Exactly one request is accepted.
- inst_ready low for 5 cycles in HOLD -> inst_valid and inst_data stable. curPC does not advance until the handshake.
- PCSrc=1, AluOutput=0x100 during WAIT -> the response for the old PC is never presented. The next request address is 0x100.
- PCSrc=1, AluOutput=0x200 with inst_ready=1 in HOLD -> the instruction is consumed and the next request address is 0x200, not PC+4.
- Reset_n pulsed low while in WAIT -> outputs return to reset values immediately. The late response is ignored, and the first request after reset is to RESET_PC.
- With FETCH_ALIGN_CHECK_EN, redirect to 0x102 -> fetch_misalign=1 and no further requests until reset.
